clock_health_monitor: RTL
=========================

// Module: clock_health_monitor
// PURPOSE
// - Consumes per-channel frequency measurements (freq_counter q outputs, e.g. fc_clk_osc, fc_clk_td) in the 125 MHz domain.
// - Once per measurement period, checks each channel against a runtime expected frequency +/- tolerance.
// - Per channel: debounced good/bad status, sticky fault flag, saturating fault counter. Also gives an all_good summary for SoC status registers.
// PARAMETERS
// - NUM_CH      2          number of monitored channels
// - REF_FREQ    125000000  clk cycles per sample period (1 s at 125 MHz)
// - GOOD_COUNT  3          consecutive in-window samples needed to declare GOOD
// PORTS
// - clk            in   1            monitor clock (clk_out_125)
// - rst            in   1            synchronous, active-high reset
// - freq_in        in   NUM_CHx32    measured frequency per channel, Hz (held between updates)
// - freq_expected  in   NUM_CHx32    nominal frequency per channel, Hz (quasi-static)
// - freq_tol       in   32           allowed |measured-expected|, Hz, shared by all channels
// - clear          in   1            1-cycle pulse; clears sticky flags and fault counters
// - sample_tick    out  1            1-cycle pulse when channels are sampled
// - ch_good        out  NUM_CH       debounced per-channel good status
// - ch_fault       out  NUM_CH       sticky per-channel fault flag
// - fault_count    out  NUM_CHx16    saturating count of out-of-window samples
// - all_good       out  1            &ch_good
// BEHAVIOUR
// - Reset values: sample_tick=0, ch_good=0, ch_fault=0, fault_count=0, all_good=0, tick counter=0. Every channel FSM goes to UNKNOWN.
// - Tick counter: 32-bit, counts 0..REF_FREQ-1 then wraps to 0.
//   - sample_tick=1 only in the cycle where the counter equals REF_FREQ-1.
//   - First tick comes REF_FREQ cycles after rst deasserts.
// - Pipeline:
//   - Tick cycle T: register freq_in.
//   - T+1: compute diff = |freq_in - freq_expected| in 33-bit unsigned; in_win = (diff <= freq_tol), so the boundary counts as in-window.
//   - T+2: FSM, ch_good, ch_fault, fault_count and all_good update. Status latency is 2 cycles after sample_tick.
// - Per-channel FSM, with a 0..GOOD_COUNT in-window run counter:
//   - UNKNOWN: in_win increments the run counter. When the run counter reaches GOOD_COUNT, go to GOOD. Out-of-window sets run counter=0, goes to BAD and counts as a fault event.
//   - GOOD: in_win stays GOOD. Out-of-window goes to BAD, run counter=0, fault event.
//   - BAD: in_win increments the run counter; at GOOD_COUNT go to GOOD. Out-of-window keeps run counter=0 and is a fault event every sample.
//   - ch_good=1 only in GOOD.
// - Fault event: ch_fault<=1; fault_count<=fault_count+1, saturating at 16'hFFFF (no wrap).
// - clear: zeros ch_fault and fault_count. It does not affect FSM state, ch_good or the tick counter.
// - clear and fault event in the same cycle: the event wins. ch_fault=1 and fault_count=1.
// - freq_in=0 (dead clock) is an ordinary out-of-window sample when freq_expected>freq_tol.
// - freq_tol >= freq_expected: 0 Hz is in-window. This is allowed, not an error.
// - rst mid-operation: any in-flight pipeline sample is discarded and all state returns to reset values in the next cycle.
// - Channels are independent; simultaneous events on several channels are all processed in the same cycle.
// TESTING (bench uses REF_FREQ=100, GOOD_COUNT=3, NUM_CH=2)
// - Lock-in: ch0 freq_in=100000000, exp=100000000, tol=1000.
//   -> first sample_tick at cycle 100 after reset.
//   -> ch_good[0]=1 two cycles after the 3rd tick; ch_fault[0]=0, fault_count[0]=0.
// - Tolerance edge: freq_in=exp+1000 -> in-window (GOOD). freq_in=exp-1001 -> BAD, ch_fault=1, fault_count=1, all_good=0.
// - Dead clock: ch1 freq_in=0 for 5 ticks -> fault_count[1]=5, ch_good[1]=0.
//   -> restore nominal: ch_good[1]=1 after exactly 3 good ticks; ch_fault[1] stays 1.
// - Clear: pulse clear with no event -> ch_fault=0, fault_count=0, ch_good unchanged.
//   -> pulse clear in the same cycle as a fault event -> fault_count=1, ch_fault=1.
// - Saturation: preload fault_count via force to 16'hFFFE, then 3 out-of-window ticks -> holds at 16'hFFFF.
// - Reset mid-run: assert rst one cycle after sample_tick -> all outputs 0.
//   -> next tick 100 cycles after rst release; FSM restarts from UNKNOWN.

Source files
------------

// File: rtl/clock_health_monitor_if.sv
// clock_health_monitor_if: measurement inputs and health status outputs of the clock monitor
interface clock_health_monitor_if #(parameter int NUM_CH = 2);
  logic [NUM_CH-1:0][31:0] freq_in;
  logic [NUM_CH-1:0][31:0] freq_expected;
  logic [31:0] freq_tol;
  logic clear;
  logic sample_tick;
  logic [NUM_CH-1:0] ch_good;
  logic [NUM_CH-1:0] ch_fault;
  logic [NUM_CH-1:0][15:0] fault_count;
  logic all_good;
  modport master (
    output freq_in, freq_expected, freq_tol, clear,
    input sample_tick, ch_good, ch_fault, fault_count, all_good
  );
  modport slave (
    input freq_in, freq_expected, freq_tol, clear,
    output sample_tick, ch_good, ch_fault, fault_count, all_good
  );
endinterface

// File: rtl/clock_health_monitor.sv
// clock_health_monitor: periodic per-channel frequency window check with debounce, sticky faults and saturating counters
module clock_health_monitor #(
  parameter int NUM_CH = 2,
  parameter int REF_FREQ = 125000000,
  parameter int GOOD_COUNT = 3
) (
  input logic clk,
  input logic rst,
  clock_health_monitor_if.slave m
);
  localparam int RW = $clog2(GOOD_COUNT + 1);
  typedef enum logic [1:0] {UNKNOWN, GOOD, BAD} st_t;
  st_t st [NUM_CH];
  logic [RW-1:0] run [NUM_CH];
  logic [31:0] cnt;
  logic tick, v;
  logic [NUM_CH-1:0][31:0] fin;
  logic [NUM_CH-1:0] in_win, good, fault;
  logic [NUM_CH-1:0][15:0] fcnt;
  assign tick = cnt == 32'(REF_FREQ - 1);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_win
    logic [32:0] diff;
    assign diff = fin[c] > m.freq_expected[c] ? {1'b0, fin[c]} - {1'b0, m.freq_expected[c]}
                                              : {1'b0, m.freq_expected[c]} - {1'b0, fin[c]};
    assign in_win[c] = diff <= {1'b0, m.freq_tol};
  end
  // a fault event in the same cycle as clear overrides it, leaving a count of one
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      v <= 1'b0;
      fin <= '0;
      good <= '0;
      fault <= '0;
      fcnt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        st[i] <= UNKNOWN;
        run[i] <= '0;
      end
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      v <= tick;
      if (tick) fin <= m.freq_in;
      for (int i = 0; i < NUM_CH; i++) begin
        if (m.clear) begin
          fault[i] <= 1'b0;
          fcnt[i] <= '0;
        end
        if (v && in_win[i] && st[i] != GOOD) begin
          run[i] <= run[i] + 1'b1;
          if (run[i] + 1'b1 == RW'(GOOD_COUNT)) begin
            st[i] <= GOOD;
            good[i] <= 1'b1;
          end
        end
        if (v && !in_win[i]) begin
          st[i] <= BAD;
          run[i] <= '0;
          good[i] <= 1'b0;
          fault[i] <= 1'b1;
          fcnt[i] <= m.clear ? 16'd1 : fcnt[i] + {15'd0, ~&fcnt[i]};
        end
      end
    end
  assign m.sample_tick = tick;
  assign m.ch_good = good;
  assign m.ch_fault = fault;
  assign m.fault_count = fcnt;
  assign m.all_good = &good;
endmodule
